// File: rtl/vTPU_pkg.sv
// Shared vTPU types: instruction record, opcode constants, dispatcher state and class enums.
package vTPU_pkg;

  localparam int unsigned OP_CODE_WIDTH = 8;

  typedef struct packed {
    logic [OP_CODE_WIDTH-1:0] op_code;
    logic [31:0]              calc_length;
    logic [15:0]              acc_address;
    logic [23:0]              buffer_address;
  } INSTRUCTION_TYPE;

  localparam INSTRUCTION_TYPE init_instruction = '0;

  localparam logic [OP_CODE_WIDTH-1:0] OP_NOP         = 8'h00;
  localparam logic [OP_CODE_WIDTH-1:0] OP_WEIGHT_LOAD = 8'h01;
  localparam logic [4:0]               OP_MATMUL_PREFIX = 5'b00001;
  localparam logic [OP_CODE_WIDTH-1:0] OP_SYNC        = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    SYNC_DRAIN
  } DISPATCH_STATE_TYPE;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WEIGHT,
    CLS_MATMUL,
    CLS_SYNC,
    CLS_ILLEGAL
  } INSTR_CLASS_TYPE;

endpackage

// File: rtl/instruction_dispatcher_opcode_classifier.sv
// Combinational opcode classifier; also usable by the look-ahead buffer's matmul check.
module opcode_classifier
  import vTPU_pkg::*;
(
  input  logic [OP_CODE_WIDTH-1:0] op_code,
  output INSTR_CLASS_TYPE          instr_class
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    if (op_code == OP_NOP)
      instr_class = CLS_NOP;
    else if (op_code == OP_WEIGHT_LOAD)
      instr_class = CLS_WEIGHT;
    else if (op_code[7:3] == OP_MATMUL_PREFIX)
      instr_class = CLS_MATMUL;
    else if (op_code == OP_SYNC)
      instr_class = CLS_SYNC;
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: holds one instruction, issues to weight/matmul unit, drains on SYNC.
// Optional performance counters enabled by DISPATCH_PERF_CNT_EN.
module instruction_dispatcher
  import vTPU_pkg::*;
#(
  parameter int unsigned UNIT_COUNT   = 2,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  INSTRUCTION_TYPE instruction_input,
  input  logic            instruction_en,
  output logic            instruction_busy,
  output INSTRUCTION_TYPE weight_instruction,
  output logic            weight_instruction_en,
  input  logic            weight_busy,
  output INSTRUCTION_TYPE matmul_instruction,
  output logic            matmul_instruction_en,
  input  logic            matmul_busy,
  output logic            synchronize,
  output logic            sync_timeout,
  output logic            illegal_opcode
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     issued_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_TIMEOUT);

  DISPATCH_STATE_TYPE state;
  INSTR_CLASS_TYPE    in_cls;
  INSTR_CLASS_TYPE    cls_q;
  INSTRUCTION_TYPE    hold;
  logic [CNT_W-1:0]   drain_cnt;
  logic               sync_timeout_q;
  logic               illegal_q;

  logic [UNIT_COUNT-1:0] unit_busy;
  logic                  any_busy;
  logic                  target_busy;
  logic                  issue;

  opcode_classifier u_classifier (
    .op_code     (instruction_input.op_code),
    .instr_class (in_cls)
  );

  assign unit_busy   = {matmul_busy, weight_busy};
  assign any_busy    = |unit_busy;
  assign target_busy = (cls_q == CLS_MATMUL) ? matmul_busy : weight_busy;

  // Strobes follow the live busy inputs so a unit freeing up is served in the same cycle.
  assign weight_instruction_en = (state == DISPATCH) && (cls_q == CLS_WEIGHT) && !weight_busy;
  assign matmul_instruction_en = (state == DISPATCH) && (cls_q == CLS_MATMUL) && !matmul_busy;
  assign issue                 = weight_instruction_en || matmul_instruction_en;

  assign weight_instruction = weight_instruction_en ? hold : init_instruction;
  assign matmul_instruction = matmul_instruction_en ? hold : init_instruction;

  assign instruction_busy = (state != IDLE);
  assign synchronize      = (state == SYNC_DRAIN) && !any_busy;
  assign sync_timeout     = sync_timeout_q;
  assign illegal_opcode   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold           <= init_instruction;
      cls_q          <= CLS_NOP;
      drain_cnt      <= '0;
      sync_timeout_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instruction_en) begin
            hold  <= instruction_input;
            cls_q <= in_cls;
            case (in_cls)
              CLS_WEIGHT, CLS_MATMUL: state <= DISPATCH;
              CLS_SYNC:               state <= SYNC_DRAIN;
              CLS_ILLEGAL:            illegal_q <= 1'b1;
              default:                ;
            endcase
          end
        end
        DISPATCH: begin
          if (issue)
            state <= IDLE;
        end
        SYNC_DRAIN: begin
          if (!any_busy) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end else begin
            if (drain_cnt != CNT_MAX)
              drain_cnt <= drain_cnt + 1'b1;
            // Flag rises on the same edge the counter lands on SYNC_TIMEOUT.
            if (drain_cnt >= CNT_MAX - 1'b1)
              sync_timeout_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic stall;
  assign stall = ((state == DISPATCH) && target_busy) || (state == SYNC_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issued_count <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (issue && (issued_count != '1))
        issued_count <= issued_count + 1'b1;
    end
  end
`else
  logic unused_target_busy;
  assign unused_target_busy = target_busy;
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench for instruction_dispatcher with a transaction-level reference model.
module tb_instruction_dispatcher;
  import vTPU_pkg::*;

  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  INSTRUCTION_TYPE instruction_input = '0;
  logic            instruction_en = 1'b0;
  logic            instruction_busy;
  INSTRUCTION_TYPE weight_instruction;
  logic            weight_instruction_en;
  logic            weight_busy = 1'b0;
  INSTRUCTION_TYPE matmul_instruction;
  logic            matmul_instruction_en;
  logic            matmul_busy = 1'b0;
  logic            synchronize;
  logic            sync_timeout;
  logic            illegal_opcode;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     issued_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          exp_illegal = 1'b0;
  bit          exp_timeout = 1'b0;
  int unsigned exp_stall   = 0;
  int unsigned exp_issued  = 0;

  always #5 clk = ~clk;

  instruction_dispatcher #(.UNIT_COUNT(2), .SYNC_TIMEOUT(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .instruction_input     (instruction_input),
    .instruction_en        (instruction_en),
    .instruction_busy      (instruction_busy),
    .weight_instruction    (weight_instruction),
    .weight_instruction_en (weight_instruction_en),
    .weight_busy           (weight_busy),
    .matmul_instruction    (matmul_instruction),
    .matmul_instruction_en (matmul_instruction_en),
    .matmul_busy           (matmul_busy),
    .synchronize           (synchronize),
    .sync_timeout          (sync_timeout),
    .illegal_opcode        (illegal_opcode)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cycles          (stall_cycles),
    .issued_count          (issued_count)
`endif
  );

  // 0 nop, 1 weight, 2 matmul, 3 sync, 4 illegal
  function automatic int class_of(input logic [7:0] op);
    if (op == 8'h00) return 0;
    if (op == 8'h01) return 1;
    if (op >= 8'h08 && op <= 8'h0F) return 2;
    if (op == 8'hFF) return 3;
    return 4;
  endfunction

  function automatic INSTRUCTION_TYPE make_instr(input logic [7:0] op);
    INSTRUCTION_TYPE r;
    r.op_code        = op;
    r.calc_length    = $urandom;
    r.acc_address    = 16'($urandom);
    r.buffer_address = 24'($urandom);
    return r;
  endfunction

  function automatic logic [7:0] rand_op(input int cls);
    logic [7:0] op;
    case (cls)
      0: op = 8'h00;
      1: op = 8'h01;
      2: op = 8'h08 + 8'($urandom_range(0, 7));
      3: op = 8'hFF;
      default: begin
        op = 8'($urandom);
        while (class_of(op) != 4) op = 8'($urandom);
      end
    endcase
    return op;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; instruction_en = 1'b0; instruction_input = '0;
    weight_busy = 1'b0; matmul_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_illegal = 1'b0; exp_timeout = 1'b0; exp_stall = 0; exp_issued = 0;
  endtask

  // Drives one instruction; wb/mb = cycles each unit reports busy after accept.
  task automatic run_instr(input INSTRUCTION_TYPE ins, input int unsigned wb,
                           input int unsigned mb, input bit trail);
    int cls;
    int unsigned last;
    bit e_busy, e_wen, e_men, e_sync;
    INSTRUCTION_TYPE e_win, e_min;
    cls = class_of(ins.op_code);
    case (cls)
      1: last = wb + 1;
      2: last = mb + 1;
      3: last = ((wb > mb) ? wb : mb) + 1;
      default: last = 0;
    endcase
    for (int unsigned k = 0; k <= last + 32'(trail); k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        instruction_input = ins; instruction_en = 1'b1;
        weight_busy = 1'($urandom_range(0, 1)); matmul_busy = 1'($urandom_range(0, 1));
      end else if (k <= last) begin
        instruction_en = 1'($urandom_range(0, 1)); instruction_input = make_instr(8'($urandom));
        weight_busy = (k <= wb); matmul_busy = (k <= mb);
      end else begin
        instruction_en = 1'b0; instruction_input = '0;
        weight_busy = 1'b0; matmul_busy = 1'b0;
      end
      e_busy = (k >= 1) && (k <= last);
      e_wen  = (cls == 1) && (k == last);
      e_men  = (cls == 2) && (k == last);
      e_sync = (cls == 3) && (k == last);
      e_win  = e_wen ? ins : '0;
      e_min  = e_men ? ins : '0;
      if (cls == 3 && k >= 1 && k <= last && (k - 1) >= TO) exp_timeout = 1'b1;
      #1;
      total++;
      if (instruction_busy !== e_busy) begin bad++;
        $display("FAIL busy op=%h k=%0d got=%b exp=%b", ins.op_code, k, instruction_busy, e_busy); end
      total++;
      if (weight_instruction_en !== e_wen || weight_instruction !== e_win) begin bad++;
        $display("FAIL weight_issue op=%h k=%0d got=%b/%h exp=%b/%h", ins.op_code, k,
                 weight_instruction_en, weight_instruction, e_wen, e_win); end
      total++;
      if (matmul_instruction_en !== e_men || matmul_instruction !== e_min) begin bad++;
        $display("FAIL matmul_issue op=%h k=%0d got=%b/%h exp=%b/%h", ins.op_code, k,
                 matmul_instruction_en, matmul_instruction, e_men, e_min); end
      total++;
      if (synchronize !== e_sync) begin bad++;
        $display("FAIL synchronize op=%h k=%0d got=%b exp=%b", ins.op_code, k, synchronize, e_sync); end
      total++;
      if (sync_timeout !== exp_timeout || illegal_opcode !== exp_illegal) begin bad++;
        $display("FAIL flags op=%h k=%0d got=%b%b exp=%b%b", ins.op_code, k,
                 sync_timeout, illegal_opcode, exp_timeout, exp_illegal); end
      if (k == 0 && cls == 4) exp_illegal = 1'b1;
    end
    case (cls)
      1: begin exp_issued++; exp_stall += wb; end
      2: begin exp_issued++; exp_stall += mb; end
      3: exp_stall += last;
      default: ;
    endcase
`ifdef DISPATCH_PERF_CNT_EN
    total++;
    if (stall_cycles !== exp_stall || issued_count !== exp_issued) begin bad++;
      $display("FAIL perf op=%h got=%0d/%0d exp=%0d/%0d", ins.op_code,
               stall_cycles, issued_count, exp_stall, exp_issued); end
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if ({instruction_busy, weight_instruction_en, matmul_instruction_en, synchronize,
         sync_timeout, illegal_opcode} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b%b%b%b%b%b exp=000000", instruction_busy, weight_instruction_en,
               matmul_instruction_en, synchronize, sync_timeout, illegal_opcode); end
    total++;
    if (weight_instruction !== '0 || matmul_instruction !== '0) begin bad++;
      $display("FAIL reset_data got=%h/%h exp=0", weight_instruction, matmul_instruction); end
  endtask

  task automatic test_weight();
    run_instr(make_instr(8'h01), 0, 3, 1);
    run_instr(make_instr(8'h01), 4, 0, 1);
  endtask

  task automatic test_matmul();
    run_instr(make_instr(8'h0A), 6, 5, 1);
  endtask

  task automatic test_sync();
    run_instr(make_instr(8'hFF), 3, 7, 1);
    run_instr(make_instr(8'hFF), 0, 0, 1);
  endtask

  task automatic test_sync_timeout();
    run_instr(make_instr(8'hFF), 20, 3, 1);
    run_instr(make_instr(8'h01), 1, 0, 1);
  endtask

  task automatic test_illegal();
    run_instr(make_instr(8'h42), 0, 0, 1);
    run_instr(make_instr(8'h00), 0, 0, 1);
    apply_reset();
    #1;
    total++;
    if (illegal_opcode !== 1'b0 || sync_timeout !== 1'b0) begin bad++;
      $display("FAIL flags_cleared got=%b%b exp=00", illegal_opcode, sync_timeout); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_instr(make_instr((i % 2) ? 8'h0F : 8'h01), 0, 0, 1'b0);
    run_instr(make_instr(8'h00), 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int cls;
      int unsigned wb, mb;
      cls = $urandom_range(0, 4);
      wb = $urandom_range(0, 6);
      mb = $urandom_range(0, 6);
      if (cls == 3 && $urandom_range(0, 3) == 0) wb = $urandom_range(17, 22);
      run_instr(make_instr(rand_op(cls)), wb, mb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_dispatch();
    @(posedge clk); #1;
    instruction_input = make_instr(8'h0C); instruction_en = 1'b1;
    matmul_busy = 1'b1; weight_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      instruction_en = 1'b0;
      #1;
      total++;
      if (instruction_busy !== 1'b1 || matmul_instruction_en !== 1'b0) begin bad++;
        $display("FAIL mid_wait i=%0d got=%b/%b exp=1/0", i, instruction_busy, matmul_instruction_en); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    matmul_busy = 1'b0;
    #1;
    total++;
    if (instruction_busy !== 1'b0 || matmul_instruction_en !== 1'b0) begin bad++;
      $display("FAIL mid_reset got=%b/%b exp=0/0", instruction_busy, matmul_instruction_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_illegal = 1'b0; exp_timeout = 1'b0; exp_stall = 0; exp_issued = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      total++;
      if (instruction_busy !== 1'b0 || matmul_instruction_en !== 1'b0 ||
          weight_instruction_en !== 1'b0) begin bad++;
        $display("FAIL post_reset i=%0d got=%b%b%b exp=000", i, instruction_busy,
                 matmul_instruction_en, weight_instruction_en); end
    end
`ifdef DISPATCH_PERF_CNT_EN
    total++;
    if (stall_cycles !== 32'd0 || issued_count !== 32'd0) begin bad++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, issued_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_weight();
    test_matmul();
    test_sync();
    test_sync_timeout();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_dispatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
